mmio_sim_responder: RTL and testbench

// - Simulation-side MMIO responder for the core under test: answers the core's uncached load/store

---
 rtl/mmio_sim_responder.sv | 242 ++++++++++++++++++++++++
 tb/tb_mmio_sim_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_sim_responder.sv
// mmio_sim_responder
//   Simulation-side MMIO responder beside the core under test. It answers
//   single-outstanding uncached loads and stores to a small register window.
//   The window provides a console byte FIFO, a tohost exit register, a 64-bit
//   cycle counter with a high-word shadow, and an optional watchdog. The
//   done/pass/timeout/exit_code outputs let the sim top end on program exit.
// Ports
//   clock, reset                 rising-edge clock; asynchronous active-low reset
//   req_valid/ready/write/addr/wdata/wstrb
//                                request channel (valid/ready)
//   rsp_valid/ready/rdata/error  response channel, held until rsp_ready
//   con_valid/ready/data         console FIFO head, popped on valid && ready
//   done, pass, timeout          sticky end-of-run flags
//   exit_code                    tohost exit code (all ones on watchdog)
module mmio_sim_responder #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_error,
  output logic              con_valid,
  input  logic              con_ready,
  output logic [7:0]        con_data,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [30:0]       exit_code
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned WORD_W = ADDR_W - 2;

  localparam logic [WORD_W-1:0] W_CONSOLE = WORD_W'(0);
  localparam logic [WORD_W-1:0] W_STATUS  = WORD_W'(1);
  localparam logic [WORD_W-1:0] W_TOHOST  = WORD_W'(2);
  localparam logic [WORD_W-1:0] W_CYC_LO  = WORD_W'(3);
  localparam logic [WORD_W-1:0] W_CYC_HI  = WORD_W'(4);

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_error_q, rsp_error_d;
  logic [7:0]         fifo_mem_q [FIFO_DEPTH];
  logic [7:0]         fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [63:0]        cycle_q, cycle_d;
  logic [31:0]        shadow_q, shadow_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               timeout_q, timeout_d;
  logic [30:0]        exit_code_q, exit_code_d;

  logic               accept;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               watchdog_hit;
  logic [WORD_W-1:0]  word;
  logic [31:0]        dec_rdata;
  logic               dec_error;
  logic               dec_push;
  logic               dec_exit;
  logic               dec_snap;
  logic               unused_addr_bits;

  always_comb begin
    word             = req_addr[ADDR_W-1:2];
    unused_addr_bits = ^req_addr[1:0];
    accept           = req_valid && (state_q == S_IDLE);
    fifo_full        = (count_q == CNT_W'(FIFO_DEPTH));
    fifo_empty       = (count_q == '0);
    pop              = !fifo_empty && con_ready;
    watchdog_hit     = (TIMEOUT_CYCLES != 0) && !done_q &&
                       (cycle_q == (64'(TIMEOUT_CYCLES) - 64'd1));
  end

  // Address decode: response data/error plus the side effect the access
  // would cause; effects only take place when the request is accepted.
  always_comb begin
    dec_rdata = '0;
    dec_error = 1'b0;
    dec_push  = 1'b0;
    dec_exit  = 1'b0;
    dec_snap  = 1'b0;
    case (word)
      W_CONSOLE: begin
        if (req_write) begin
          // Full is judged before any same-cycle pop, so a push to a full
          // FIFO is always rejected.
          if (!req_wstrb[0] || fifo_full) dec_error = 1'b1;
          else                            dec_push  = 1'b1;
        end
      end
      W_STATUS: begin
        if (req_write) dec_error = 1'b1;
        else           dec_rdata = {16'b0, 8'(count_q), 6'b0, fifo_full, fifo_empty};
      end
      W_TOHOST: begin
        if (req_write) begin
          if (req_wstrb != 4'hF) dec_error = 1'b1;
          else                   dec_exit  = req_wdata[0] && !done_q;
        end else begin
          dec_rdata = {exit_code_q, done_q};
        end
      end
      W_CYC_LO: begin
        if (req_write) begin
          dec_error = 1'b1;
        end else begin
          dec_rdata = cycle_q[31:0];
          dec_snap  = 1'b1;
        end
      end
      W_CYC_HI: begin
        if (req_write) dec_error = 1'b1;
        else           dec_rdata = shadow_q;
      end
      default: dec_error = 1'b1;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state
  always_comb begin
    push        = accept && dec_push;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    fifo_mem_d  = fifo_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    cycle_d     = cycle_q;
    shadow_d    = shadow_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    exit_code_d = exit_code_q;

    if (accept) begin
      rsp_rdata_d = dec_rdata;
      rsp_error_d = dec_error;
      if (dec_snap) shadow_d = cycle_q[63:32];
    end

    if (push) begin
      fifo_mem_d[wr_ptr_q] = req_wdata[7:0];
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (!done_q) cycle_d = cycle_q + 64'd1;

    // A tohost exit in the same cycle as the watchdog limit takes priority.
    if (accept && dec_exit) begin
      done_d      = 1'b1;
      exit_code_d = req_wdata[31:1];
      pass_d      = (req_wdata[31:1] == '0);
    end else if (watchdog_hit) begin
      done_d      = 1'b1;
      timeout_d   = 1'b1;
      pass_d      = 1'b0;
      exit_code_d = '1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      fifo_mem_q  <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cycle_q     <= '0;
      shadow_q    <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      exit_code_q <= '0;
    end else begin
      state_q     <= state_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      fifo_mem_q  <= fifo_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cycle_q     <= cycle_d;
      shadow_q    <= shadow_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      exit_code_q <= exit_code_d;
    end
  end

  // Outputs
  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    rsp_rdata = rsp_rdata_q;
    rsp_error = rsp_error_q;
    con_valid = !fifo_empty;
    con_data  = fifo_empty ? 8'h00 : fifo_mem_q[rd_ptr_q];
    done      = done_q;
    pass      = pass_q;
    timeout   = timeout_q;
    exit_code = exit_code_q;
  end

endmodule

// File: tb/tb_mmio_sim_responder.sv
module tb_mmio_sim_responder;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, reset_wd;
  logic        req_valid, req_write, rsp_ready, con_ready;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        req_ready, rsp_valid, rsp_error, con_valid, done, pass, timeout;
  logic [31:0] rsp_rdata;
  logic [7:0]  con_data;
  logic [30:0] exit_code;

  logic        wd_req_ready, wd_rsp_valid, wd_rsp_error, wd_con_valid;
  logic        wd_done, wd_pass, wd_timeout;
  logic [31:0] wd_rsp_rdata;
  logic [7:0]  wd_con_data;
  logic [30:0] wd_exit_code;

  mmio_sim_responder #(.ADDR_W(8), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(0)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .con_valid(con_valid), .con_ready(con_ready), .con_data(con_data),
    .done(done), .pass(pass), .timeout(timeout), .exit_code(exit_code)
  );

  mmio_sim_responder #(.ADDR_W(8), .FIFO_DEPTH(16), .TIMEOUT_CYCLES(50)) dut_wd (
    .clock(clock), .reset(reset_wd),
    .req_valid(1'b0), .req_ready(wd_req_ready), .req_write(1'b0),
    .req_addr(8'h00), .req_wdata(32'h0), .req_wstrb(4'h0),
    .rsp_valid(wd_rsp_valid), .rsp_ready(1'b1), .rsp_rdata(wd_rsp_rdata), .rsp_error(wd_rsp_error),
    .con_valid(wd_con_valid), .con_ready(1'b0), .con_data(wd_con_data),
    .done(wd_done), .pass(wd_pass), .timeout(wd_timeout), .exit_code(wd_exit_code)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard of expected responses, pushed when a request is driven.
  logic [31:0] sb_rdata_q[$];
  logic        sb_err_q[$];
  string       sb_name_q[$];

  always @(negedge clock) begin
    if (reset && rsp_valid && rsp_ready) begin
      if (sb_rdata_q.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        automatic logic [31:0] er = sb_rdata_q.pop_front();
        automatic logic        ee = sb_err_q.pop_front();
        automatic string       nm = sb_name_q.pop_front();
        chk({nm, "_rdata"}, rsp_rdata, er);
        chk({nm, "_err"}, rsp_error, ee);
      end
    end
  end

  // Reference cycle counter: counts edges after reset release until exit.
  int unsigned model_cyc;
  logic        model_done;
  always @(posedge clock or negedge reset) begin
    if (!reset)           model_cyc <= 0;
    else if (!model_done) model_cyc <= model_cyc + 1;
  end

  task automatic xact(input string name, input logic w, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input logic [31:0] er, input logic ee,
                      input bit use_cyc = 0, input bit do_pop = 0, input int hold = 0);
    int n;
    @(negedge clock);
    chk({name, "_idle_ready"}, req_ready, 1'b1);
    if (use_cyc) er = model_cyc;
    sb_rdata_q.push_back(er);
    sb_err_q.push_back(ee);
    sb_name_q.push_back(name);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
    if (do_pop) con_ready = 1'b1;
    if (hold > 0) rsp_ready = 1'b0;
    @(negedge clock);
    req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 32'h0; req_wstrb = 4'h0;
    if (do_pop) con_ready = 1'b0;
    if (w && a[7:2] == 6'h02 && s == 4'hF && d[0]) model_done = 1'b1;
    chk({name, "_rsp_next"}, rsp_valid, 1'b1);
    chk({name, "_busy"}, req_ready, 1'b0);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        chk({name, "_hold_v"}, rsp_valid, 1'b1);
        chk({name, "_hold_d"}, {rsp_error, rsp_rdata}, {ee, er});
        @(posedge clock); #1;
      end
      rsp_ready = 1'b1;
    end
    n = 0;
    while (rsp_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (rsp_valid) chk({name, "_rsp_drain_timeout"}, 64'd1, 64'd0);
  endtask

  typedef struct {
    logic        w;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [14];
  logic [7:0] drain_exp [3];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    reset = 1'b0; reset_wd = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 32'h0; req_wstrb = 4'h0;
    rsp_ready = 1'b1; con_ready = 1'b0; model_done = 1'b0;

    vecs[0]  = '{1'b0, 8'h04, 32'h0,  4'h0, 32'h0000_0001, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 32'h0,  4'h0, 32'h0,         1'b0};
    vecs[2]  = '{1'b0, 8'h08, 32'h0,  4'h0, 32'h0,         1'b0};
    vecs[3]  = '{1'b0, 8'h10, 32'h0,  4'h0, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, 8'h20, 32'h0,  4'h0, 32'h0,         1'b1};
    vecs[5]  = '{1'b0, 8'h14, 32'h0,  4'h0, 32'h0,         1'b1};
    vecs[6]  = '{1'b1, 8'h04, 32'h5,  4'hF, 32'h0,         1'b1};
    vecs[7]  = '{1'b1, 8'h0C, 32'h5,  4'hF, 32'h0,         1'b1};
    vecs[8]  = '{1'b1, 8'h10, 32'h5,  4'hF, 32'h0,         1'b1};
    vecs[9]  = '{1'b1, 8'h00, 32'h41, 4'hE, 32'h0,         1'b1};
    vecs[10] = '{1'b1, 8'h08, 32'h1,  4'h7, 32'h0,         1'b1};
    vecs[11] = '{1'b1, 8'h08, 32'h0,  4'hF, 32'h0,         1'b0};
    vecs[12] = '{1'b0, 8'h07, 32'h0,  4'h0, 32'h0000_0001, 1'b0};
    vecs[13] = '{1'b1, 8'hFC, 32'h1,  4'hF, 32'h0,         1'b1};

    repeat (3) @(negedge clock);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp", {rsp_valid, rsp_error, rsp_rdata}, 34'h0);
    chk("rst_con", {con_valid, con_data}, 9'h0);
    chk("rst_flags", {done, pass, timeout, exit_code}, 34'h0);
    reset = 1'b1; reset_wd = 1'b1;

    // Watchdog: fires on the 50th edge after release.
    repeat (49) @(posedge clock);
    #1 chk("wd_not_yet", wd_done, 1'b0);
    @(posedge clock);
    #1;
    chk("wd_done", {wd_done, wd_timeout, wd_pass}, 3'b110);
    chk("wd_exit_code", wd_exit_code, 31'h7FFF_FFFF);

    for (int i = 0; i < 14; i++)
      xact($sformatf("vec%0d", i), vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
           vecs[i].exp_rdata, vecs[i].exp_err);
    chk("tbl_no_done", done, 1'b0);
    chk("tbl_fifo_empty", con_valid, 1'b0);

    // Console "Hi"
    xact("push_H", 1'b1, 8'h00, 32'h48, 4'h1, 32'h0, 1'b0);
    xact("push_i", 1'b1, 8'h00, 32'h69, 4'h1, 32'h0, 1'b0);
    xact("stat_2", 1'b0, 8'h04, 32'h0, 4'h0, 32'h0000_0200, 1'b0);
    chk("con_head_H", {con_valid, con_data}, 9'h148);
    con_ready = 1'b1;
    @(negedge clock);
    chk("con_head_i", {con_valid, con_data}, 9'h169);
    @(negedge clock);
    chk("con_empty", con_valid, 1'b0);
    con_ready = 1'b0;

    // Fill to depth 4, overflow, and push+pop while full
    xact("fill_a", 1'b1, 8'h00, 32'h61, 4'h1, 32'h0, 1'b0);
    xact("fill_b", 1'b1, 8'h00, 32'h62, 4'h1, 32'h0, 1'b0);
    xact("fill_c", 1'b1, 8'h00, 32'h63, 4'h1, 32'h0, 1'b0);
    xact("fill_d", 1'b1, 8'h00, 32'h64, 4'h1, 32'h0, 1'b0);
    xact("fill_e", 1'b1, 8'h00, 32'h65, 4'h1, 32'h0, 1'b1);
    xact("stat_full", 1'b0, 8'h04, 32'h0, 4'h0, 32'h0000_0402, 1'b0);
    chk("full_head", con_data, 8'h61);
    xact("full_pushpop", 1'b1, 8'h00, 32'h66, 4'h1, 32'h0, 1'b1, 1'b0, 1'b1);
    xact("stat_3", 1'b0, 8'h04, 32'h0, 4'h0, 32'h0000_0300, 1'b0);
    drain_exp[0] = 8'h62; drain_exp[1] = 8'h63; drain_exp[2] = 8'h64;
    con_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("drain%0d", i), {con_valid, con_data}, {1'b1, drain_exp[i]});
      @(negedge clock);
    end
    chk("drained", con_valid, 1'b0);
    con_ready = 1'b0;

    // Push+pop when not full keeps count and order
    xact("push_x", 1'b1, 8'h00, 32'h78, 4'h1, 32'h0, 1'b0);
    xact("pushpop_y", 1'b1, 8'h00, 32'h79, 4'h1, 32'h0, 1'b0, 1'b0, 1'b1);
    xact("stat_1", 1'b0, 8'h04, 32'h0, 4'h0, 32'h0000_0100, 1'b0);
    chk("head_y", {con_valid, con_data}, 9'h179);
    con_ready = 1'b1;
    @(negedge clock);
    con_ready = 1'b0;
    chk("empty_y", con_valid, 1'b0);

    // Cycle counter and held response
    xact("cyc_lo", 1'b0, 8'h0C, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1);
    xact("cyc_hi", 1'b0, 8'h10, 32'h0, 4'h0, 32'h0, 1'b0);
    xact("hold_bad", 1'b0, 8'h20, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5);

    // Exit with code 0, then a second exit is ignored
    xact("exit0", 1'b1, 8'h08, 32'h1, 4'hF, 32'h0, 1'b0);
    chk("exit0_flags", {done, pass, timeout}, 3'b110);
    chk("exit0_code", exit_code, 31'h0);
    xact("exit_again", 1'b1, 8'h08, 32'h7, 4'hF, 32'h0, 1'b0);
    chk("exit_again_code", {pass, exit_code}, {1'b1, 31'h0});
    xact("th_rd0", 1'b0, 8'h08, 32'h0, 4'h0, 32'h0000_0001, 1'b0);
    xact("frz_a", 1'b0, 8'h0C, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1);
    xact("frz_b", 1'b0, 8'h0C, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1);
    xact("con_after_done", 1'b1, 8'h00, 32'h7A, 4'h1, 32'h0, 1'b0);
    chk("con_after_done_head", {con_valid, con_data}, 9'h17A);

    // Reset in the middle of a held response drops it
    @(negedge clock);
    rsp_ready = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h04;
    @(negedge clock);
    req_valid = 1'b0;
    chk("pre_rst_rspv", rsp_valid, 1'b1);
    reset = 1'b0; model_done = 1'b0;
    #1;
    chk("mid_rst_rsp", {req_ready, rsp_valid, rsp_error, rsp_rdata}, {2'b10, 33'h0});
    chk("mid_rst_con", {con_valid, con_data}, 9'h0);
    chk("mid_rst_flags", {done, pass, timeout, exit_code}, 34'h0);
    rsp_ready = 1'b1;
    @(negedge clock);
    reset = 1'b1;

    // Exit with code 3
    xact("exit3", 1'b1, 8'h08, 32'h7, 4'hF, 32'h0, 1'b0);
    chk("exit3_flags", {done, pass, timeout}, 3'b100);
    chk("exit3_code", exit_code, 31'd3);
    xact("th_rd3", 1'b0, 8'h08, 32'h0, 4'h0, 32'h0000_0007, 1'b0);
    xact("frz3_a", 1'b0, 8'h0C, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1);
    xact("frz3_b", 1'b0, 8'h0C, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1);
    chk("sb_empty", sb_rdata_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
